decode_unit: RTL and testbench
==============================

# decode_unit

Parametrised, handshaked instruction decoder for the RISC core. It sits between instruction fetch and the register file/ALU. It accepts one instruction per cycle over a valid/ready interface and drives registered register-file selects, ALU op, immediate and write-enable. It adds multi-cycle MUL sequencing, a HALT state and sticky illegal-opcode detection.

## Interface
- `INSTR_W`, default 16: instruction width; must be ≥ OPC_W + 3·REG_ADDR_W + 2.
- `OPC_W`, default 5: opcode width; the opcode occupies the top OPC_W bits.
- `REG_ADDR_W`, default 3: register address width.
- `IMM_W`, default 8: immediate width; the immediate occupies `instruction[IMM_W-1:0]`.
- `MUL_CYCLES`, default 4: MUL occupancy in cycles; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: the instruction word is valid.
- `instr_ready` out 1: the decoder can accept; equals (state==RUN) && !rst.
- `instruction` in INSTR_W: instruction word.
- `reg_sel_w0` out REG_ADDR_W: write-port select (rd).
- `reg_sel_r0` out REG_ADDR_W: read-port-0 select.
- `reg_sel_r1` out REG_ADDR_W: read-port-1 select (rs2).
- `reg_w0_rw` out 1: one-cycle register write strobe.
- `alu_op` out 4: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MUL, 7 PASS_IMM.
- `imm_sel` out 1: the ALU B operand is `imm_out`.
- `imm_out` out IMM_W: raw immediate field.
- `ctrl_valid` out 1: one-cycle pulse; the outputs above describe a completed decode.
- `halted` out 1: HALT executed; stays set until reset.
- `illegal` out 1: sticky; an unknown opcode was accepted.

## Operation
- Fields, from the MSB down:
  - opcode;
  - rd = `[INSTR_W-OPC_W-1 -: REG_ADDR_W]`;
  - rs1 = the next REG_ADDR_W bits;
  - rs2 = the next REG_ADDR_W bits.
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR: w0=rd, r0=rs1, r1=rs2, imm_sel=0.
  - 00101 ADDI: w0=rd, r0=rd, alu_op=ADD, imm_sel=1.
  - 00110 LDI: w0=rd, alu_op=PASS_IMM, imm_sel=1.
  - 00111 MUL: same selects as ADD, alu_op=MUL, multi-cycle.
  - 01000 NOP: ctrl_valid=1, reg_w0_rw=0, alu_op=NOP.
  - 11111 HALT: no write; enters HALT.
  - Any other opcode is illegal: it decodes as NOP, sets `illegal`, and the decoder stays in RUN.
- States:
  - RUN:
    - An accept (valid && ready) of a single-cycle op registers the outputs and pulses ctrl_valid.
    - An accept of MUL loads cnt = MUL_CYCLES-2, registers the selects and alu_op with reg_w0_rw=0 and ctrl_valid=0, and moves to MUL.
    - An accept of HALT moves to HALT.
    - A cycle with no accept forces reg_w0_rw=0 and ctrl_valid=0; the selects hold their last values.
  - MUL:
    - Each edge decrements cnt.
    - At the edge with cnt==0: reg_w0_rw=1, ctrl_valid=1, return to RUN.
  - HALT:
    - halted=1, instr_ready=0, and all strobes are 0.
    - Only reset leaves this state.
- Counter width is $clog2(MUL_CYCLES); it never wraps because it is reloaded only from RUN.

## Timing
- Reset (async assert):
  - state=RUN, cnt=0.
  - All outputs are 0, including selects, alu_op, imm_out, halted and illegal.
  - instr_ready is 0 while rst is high and 1 in the first cycle after release.
- Single-cycle op accepted at edge N: outputs valid in cycle N+1 (latency 1). Back-to-back throughput is 1 per cycle.
- MUL accepted at edge N:
  - instr_ready is low for cycles N+1 … N+MUL_CYCLES-1.
  - reg_w0_rw and ctrl_valid pulse in cycle N+MUL_CYCLES.
  - instr_ready is high again in the same cycle as the pulse, so the next instruction can be accepted at edge N+MUL_CYCLES.
- `instruction` is sampled only on an accept. Changing it while ready=0 has no effect.
- Reset asserted mid-MUL aborts the MUL: no write pulse, and outputs clear immediately.
- An illegal op and a HALT are never accepted in the same cycle (there is one instruction per cycle). `illegal` remains set through HALT.

## Configuration
- `DECODE_MUL_EN`:
  - Defined: MUL (00111) executes as described, using MUL_CYCLES.
  - Undefined: 00111 is an illegal opcode (NOP plus `illegal`). The MUL state and counter are not synthesised, and instr_ready depends only on RUN/HALT.

## Test plan
- Reset, then ADD r3,r1,r2 (16'h0328) with valid=1:
  - cycle after accept: w0=3, r0=1, r1=2, alu_op=1, imm_sel=0, reg_w0_rw=1, ctrl_valid=1;
  - next cycle, with valid=0: both strobes are 0.
- ADDI r2,#0x7F (16'h2A7F) immediately followed by SUB in the next cycle:
  - first: w0=2, r0=2, imm_out=8'h7F, imm_sel=1, alu_op=1;
  - second: alu_op=2 one cycle later, with no bubble.
- MUL r4,r5,r6 (16'h3CB8) with `DECODE_MUL_EN` defined and MUL_CYCLES=4, accepted at edge N:
  - ready=0 for 3 cycles;
  - single reg_w0_rw pulse with w0=4 in cycle N+4;
  - the next instruction is accepted at edge N+4.
- Same MUL with rst pulsed at cycle N+2: no write pulse, and all outputs are 0 after reset.
- Opcode 10000 (16'h8000), then HALT (16'hF800):
  - illegal=1 with no write;
  - then halted=1 and ready=0 while valid is held high for 10 cycles;
  - a reset clears both flags.
- With `DECODE_MUL_EN` undefined, 16'h3CB8 sets illegal=1, reg_w0_rw never asserts, and ready stays 1.

Source files
------------

// File: rtl/decode_unit.sv
// ---------------------------------------------------------------------------
// decode_unit
//
// Handshaked instruction decoder sitting between instruction fetch and the
// register file / ALU. One instruction is accepted per cycle over a
// valid/ready pair. The decoded register selects, ALU op, immediate and write
// strobe are registered, so a decode accepted at one edge is visible in the
// following cycle.
//
// Instruction layout, MSB first:
//   opcode [INSTR_W-1 -: OPC_W]
//   rd     [INSTR_W-OPC_W-1 -: REG_ADDR_W]
//   rs1    next REG_ADDR_W bits
//   rs2    next REG_ADDR_W bits
//   imm    [IMM_W-1:0] (overlaps the register fields)
//
// Build option:
//   DECODE_MUL_EN - when defined, opcode 00111 is a multi-cycle MUL that
//                   holds the decoder for MUL_CYCLES cycles. When undefined,
//                   00111 is illegal and no MUL state or counter exists.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   instr_valid  in   instruction word is valid
//   instr_ready  out  decoder can accept (RUN state and not in reset)
//   instruction  in   instruction word, sampled only on an accept
//   reg_sel_w0   out  write-port select (rd)
//   reg_sel_r0   out  read-port-0 select
//   reg_sel_r1   out  read-port-1 select
//   reg_w0_rw    out  one-cycle register write strobe
//   alu_op       out  0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 MUL,7 PASS_IMM
//   imm_sel      out  ALU B operand is imm_out
//   imm_out      out  raw immediate field
//   ctrl_valid   out  one-cycle pulse marking a completed decode
//   halted       out  HALT executed; held until reset
//   illegal      out  sticky; an unknown opcode was accepted
//
// Ops that do not name a register field (ADDI, LDI, NOP, illegal) still load
// the raw field values into the selects; consumers qualify them with
// reg_w0_rw / alu_op. HALT leaves the selects untouched.
// ---------------------------------------------------------------------------
module decode_unit #(
    parameter int INSTR_W    = 16,
    parameter int OPC_W      = 5,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instruction,
    output logic [REG_ADDR_W-1:0] reg_sel_w0,
    output logic [REG_ADDR_W-1:0] reg_sel_r0,
    output logic [REG_ADDR_W-1:0] reg_sel_r1,
    output logic                  reg_w0_rw,
    output logic [3:0]            alu_op,
    output logic                  imm_sel,
    output logic [IMM_W-1:0]      imm_out,
    output logic                  ctrl_valid,
    output logic                  halted,
    output logic                  illegal
);

    // Elaboration-time parameter sanity checks.
    if (INSTR_W < OPC_W + 3 * REG_ADDR_W + 2) begin : g_bad_instr_w
        $error("decode_unit: INSTR_W too small for the field layout");
    end
    if (MUL_CYCLES < 2) begin : g_bad_mul_cycles
        $error("decode_unit: MUL_CYCLES must be at least 2");
    end

    // ALU operation encodings.
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_MUL  = 4'd6;
    localparam logic [3:0] ALU_PASS = 4'd7;

    // Opcode encodings.
    localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OPC_OR   = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OPC_XOR  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(5'b00110);
`ifdef DECODE_MUL_EN
    localparam logic [OPC_W-1:0] OPC_MUL  = OPC_W'(5'b00111);
`endif
    localparam logic [OPC_W-1:0] OPC_NOP  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(5'b11111);

`ifdef DECODE_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
`ifdef DECODE_MUL_EN
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif
    logic [REG_ADDR_W-1:0]   w0_q, w0_d;
    logic [REG_ADDR_W-1:0]   r0_q, r0_d;
    logic [REG_ADDR_W-1:0]   r1_q, r1_d;
    logic                    rw_q, rw_d;
    logic [3:0]              alu_q, alu_d;
    logic                    isel_q, isel_d;
    logic [IMM_W-1:0]        imm_q, imm_d;
    logic                    cv_q, cv_d;
    logic                    halted_q, halted_d;
    logic                    illegal_q, illegal_d;

    // Instruction field extraction.
    logic [OPC_W-1:0]        opc_s;
    logic [REG_ADDR_W-1:0]   rd_s;
    logic [REG_ADDR_W-1:0]   rs1_s;
    logic [REG_ADDR_W-1:0]   rs2_s;
    logic [IMM_W-1:0]        imm_s;
    logic                    accept_s;

    assign opc_s = instruction[INSTR_W-1 -: OPC_W];
    assign rd_s  = instruction[INSTR_W-OPC_W-1 -: REG_ADDR_W];
    assign rs1_s = instruction[INSTR_W-OPC_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign rs2_s = instruction[INSTR_W-OPC_W-2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign imm_s = instruction[IMM_W-1:0];

    // Ready drops combinationally with rst so nothing is handed over during reset.
    assign instr_ready = (state_q == ST_RUN) && !rst;
    assign accept_s    = instr_valid && instr_ready;

    // Next-state and decode logic.
    always_comb begin
        state_d   = state_q;
`ifdef DECODE_MUL_EN
        cnt_d     = cnt_q;
`endif
        w0_d      = w0_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        alu_d     = alu_q;
        isel_d    = isel_q;
        imm_d     = imm_q;
        rw_d      = 1'b0;
        cv_d      = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_RUN: begin
                if (!accept_s) begin
                    // Idle cycle: strobes fall, selects hold.
                    state_d = ST_RUN;
                end else if (opc_s == OPC_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    w0_d   = rd_s;
                    r0_d   = rs1_s;
                    r1_d   = rs2_s;
                    imm_d  = imm_s;
                    isel_d = 1'b0;
                    alu_d  = ALU_NOP;
                    case (opc_s)
                        OPC_ADD: begin
                            alu_d = ALU_ADD;
                            rw_d  = 1'b1;
                            cv_d  = 1'b1;
                        end
                        OPC_SUB: begin
                            alu_d = ALU_SUB;
                            rw_d  = 1'b1;
                            cv_d  = 1'b1;
                        end
                        OPC_AND: begin
                            alu_d = ALU_AND;
                            rw_d  = 1'b1;
                            cv_d  = 1'b1;
                        end
                        OPC_OR: begin
                            alu_d = ALU_OR;
                            rw_d  = 1'b1;
                            cv_d  = 1'b1;
                        end
                        OPC_XOR: begin
                            alu_d = ALU_XOR;
                            rw_d  = 1'b1;
                            cv_d  = 1'b1;
                        end
                        OPC_ADDI: begin
                            // Accumulate into rd: read port 0 reads rd itself.
                            r0_d   = rd_s;
                            alu_d  = ALU_ADD;
                            isel_d = 1'b1;
                            rw_d   = 1'b1;
                            cv_d   = 1'b1;
                        end
                        OPC_LDI: begin
                            alu_d  = ALU_PASS;
                            isel_d = 1'b1;
                            rw_d   = 1'b1;
                            cv_d   = 1'b1;
                        end
`ifdef DECODE_MUL_EN
                        OPC_MUL: begin
                            // Write strobe is deferred to the last MUL cycle.
                            alu_d   = ALU_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES - 2);
                            state_d = ST_MUL;
                        end
`endif
                        OPC_NOP: begin
                            cv_d = 1'b1;
                        end
                        default: begin
                            // Unknown opcode behaves as NOP and flags it.
                            cv_d      = 1'b1;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
`ifdef DECODE_MUL_EN
            ST_MUL: begin
                if (cnt_q == '0) begin
                    rw_d    = 1'b1;
                    cv_d    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
`ifdef DECODE_MUL_EN
            cnt_q     <= '0;
`endif
            w0_q      <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            rw_q      <= 1'b0;
            alu_q     <= 4'd0;
            isel_q    <= 1'b0;
            imm_q     <= '0;
            cv_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
`ifdef DECODE_MUL_EN
            cnt_q     <= cnt_d;
`endif
            w0_q      <= w0_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            rw_q      <= rw_d;
            alu_q     <= alu_d;
            isel_q    <= isel_d;
            imm_q     <= imm_d;
            cv_q      <= cv_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign reg_sel_w0 = w0_q;
    assign reg_sel_r0 = r0_q;
    assign reg_sel_r1 = r1_q;
    assign reg_w0_rw  = rw_q;
    assign alu_op     = alu_q;
    assign imm_sel    = isel_q;
    assign imm_out    = imm_q;
    assign ctrl_valid = cv_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_decode_unit.sv
// ---------------------------------------------------------------------------
// tb_decode_unit
//
// Directed bench for decode_unit with default parameters. A table of
// single-cycle vectors is applied back to back; hand-written sequences cover
// MUL occupancy, reset during MUL, illegal opcodes and HALT. Builds with and
// without DECODE_MUL_EN.
// ---------------------------------------------------------------------------
module tb_decode_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [2:0]  reg_sel_w0;
    logic [2:0]  reg_sel_r0;
    logic [2:0]  reg_sel_r1;
    logic        reg_w0_rw;
    logic [3:0]  alu_op;
    logic        imm_sel;
    logic [7:0]  imm_out;
    logic        ctrl_valid;
    logic        halted;
    logic        illegal;

    int n_checks;
    int n_fail;

    decode_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .reg_sel_w0  (reg_sel_w0),
        .reg_sel_r0  (reg_sel_r0),
        .reg_sel_r1  (reg_sel_r1),
        .reg_w0_rw   (reg_w0_rw),
        .alu_op      (alu_op),
        .imm_sel     (imm_sel),
        .imm_out     (imm_out),
        .ctrl_valid  (ctrl_valid),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] instr;
        logic [2:0]  w0;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic [3:0]  alu;
        logic        isel;
        logic [7:0]  imm;
        logic        rw;
        logic        cv;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " w0"},      32'(reg_sel_w0), 32'd0);
        chk({tag, " r0"},      32'(reg_sel_r0), 32'd0);
        chk({tag, " r1"},      32'(reg_sel_r1), 32'd0);
        chk({tag, " rw"},      32'(reg_w0_rw),  32'd0);
        chk({tag, " alu"},     32'(alu_op),     32'd0);
        chk({tag, " isel"},    32'(imm_sel),    32'd0);
        chk({tag, " imm"},     32'(imm_out),    32'd0);
        chk({tag, " cv"},      32'(ctrl_valid), 32'd0);
        chk({tag, " halted"},  32'(halted),     32'd0);
        chk({tag, " illegal"}, 32'(illegal),    32'd0);
        chk({tag, " ready"},   32'(instr_ready), 32'd0);
    endtask

    // Assert reset, check the cleared outputs, release, check ready returns.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst         = 1'b1;
        instr_valid = 1'b0;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({tag, " ready after release"}, 32'(instr_ready), 32'd1);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = 16'h0000;

        //          valid  instr      w0    r0    r1    alu   isel  imm     rw    cv
        tbl[0] = '{1'b1, 16'h0328, 3'd3, 3'd1, 3'd2, 4'd1, 1'b0, 8'h28, 1'b1, 1'b1}; // ADD r3,r1,r2
        tbl[1] = '{1'b0, 16'h0328, 3'd3, 3'd1, 3'd2, 4'd1, 1'b0, 8'h28, 1'b0, 1'b0}; // idle
        tbl[2] = '{1'b1, 16'h2A7F, 3'd2, 3'd2, 3'd7, 4'd1, 1'b1, 8'h7F, 1'b1, 1'b1}; // ADDI r2,#7F
        tbl[3] = '{1'b1, 16'h0DDC, 3'd5, 3'd6, 3'd7, 4'd2, 1'b0, 8'hDC, 1'b1, 1'b1}; // SUB r5,r6,r7
        tbl[4] = '{1'b1, 16'h114C, 3'd1, 3'd2, 3'd3, 4'd3, 1'b0, 8'h4C, 1'b1, 1'b1}; // AND r1,r2,r3
        tbl[5] = '{1'b1, 16'h1F04, 3'd7, 3'd0, 3'd1, 4'd4, 1'b0, 8'h04, 1'b1, 1'b1}; // OR  r7,r0,r1
        tbl[6] = '{1'b1, 16'h20F8, 3'd0, 3'd7, 3'd6, 4'd5, 1'b0, 8'hF8, 1'b1, 1'b1}; // XOR r0,r7,r6
        tbl[7] = '{1'b1, 16'h36A5, 3'd6, 3'd5, 3'd1, 4'd7, 1'b1, 8'hA5, 1'b1, 1'b1}; // LDI r6,#A5
        tbl[8] = '{1'b1, 16'h4000, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1}; // NOP
        tbl[9] = '{1'b0, 16'h0328, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0}; // idle, word ignored

        // Reset state while rst is held from time zero.
        #2;
        chk_all_zero("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("por ready after release", 32'(instr_ready), 32'd1);

        // Back-to-back single-cycle decodes.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_valid = tbl[i].valid;
            instruction = tbl[i].instr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d w0", i),    32'(reg_sel_w0), 32'(tbl[i].w0));
            chk($sformatf("vec%0d r0", i),    32'(reg_sel_r0), 32'(tbl[i].r0));
            chk($sformatf("vec%0d r1", i),    32'(reg_sel_r1), 32'(tbl[i].r1));
            chk($sformatf("vec%0d alu", i),   32'(alu_op),     32'(tbl[i].alu));
            chk($sformatf("vec%0d isel", i),  32'(imm_sel),    32'(tbl[i].isel));
            chk($sformatf("vec%0d imm", i),   32'(imm_out),    32'(tbl[i].imm));
            chk($sformatf("vec%0d rw", i),    32'(reg_w0_rw),  32'(tbl[i].rw));
            chk($sformatf("vec%0d cv", i),    32'(ctrl_valid), 32'(tbl[i].cv));
            chk($sformatf("vec%0d ready", i), 32'(instr_ready), 32'd1);
            chk($sformatf("vec%0d illegal", i), 32'(illegal),  32'd0);
        end

`ifdef DECODE_MUL_EN
        // MUL r4,r5,r6 accepted at edge N; an ADD is held on the bus meanwhile.
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = 16'h3CB8;
        @(posedge clk);
        @(negedge clk);
        instruction = 16'h0328;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("mul busy%0d ready", k), 32'(instr_ready), 32'd0);
            chk($sformatf("mul busy%0d rw", k),    32'(reg_w0_rw),   32'd0);
            chk($sformatf("mul busy%0d cv", k),    32'(ctrl_valid),  32'd0);
            chk($sformatf("mul busy%0d alu", k),   32'(alu_op),      32'd6);
            @(posedge clk);
            #1;
        end
        chk("mul done rw",    32'(reg_w0_rw),   32'd1);
        chk("mul done cv",    32'(ctrl_valid),  32'd1);
        chk("mul done w0",    32'(reg_sel_w0),  32'd4);
        chk("mul done r0",    32'(reg_sel_r0),  32'd5);
        chk("mul done r1",    32'(reg_sel_r1),  32'd6);
        chk("mul done alu",   32'(alu_op),      32'd6);
        chk("mul done ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post mul accept w0",  32'(reg_sel_w0), 32'd3);
        chk("post mul accept alu", 32'(alu_op),     32'd1);
        chk("post mul accept rw",  32'(reg_w0_rw),  32'd1);
        @(negedge clk);
        instr_valid = 1'b0;

        // Reset in the middle of a MUL aborts it without a write.
        do_reset("pre abort");
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = 16'h3CB8;
        @(posedge clk);
        #1;
        chk("abort busy ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort after%0d rw", k),    32'(reg_w0_rw),   32'd0);
            chk($sformatf("abort after%0d ready", k), 32'(instr_ready), 32'd1);
        end
`else
        // Without MUL support 00111 is just an illegal opcode.
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = 16'h3CB8;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nomul%0d illegal", k), 32'(illegal),     32'd1);
            chk($sformatf("nomul%0d rw", k),      32'(reg_w0_rw),   32'd0);
            chk($sformatf("nomul%0d ready", k),   32'(instr_ready), 32'd1);
            chk($sformatf("nomul%0d alu", k),     32'(alu_op),      32'd0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
`endif

        // Illegal opcode, then HALT held on the bus.
        do_reset("pre illegal");
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = 16'h8000;
        @(posedge clk);
        #1;
        chk("illegal flag",  32'(illegal),    32'd1);
        chk("illegal rw",    32'(reg_w0_rw),  32'd0);
        chk("illegal alu",   32'(alu_op),     32'd0);
        chk("illegal cv",    32'(ctrl_valid), 32'd1);
        chk("illegal ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instruction = 16'hF800;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("halt%0d halted", k),  32'(halted),      32'd1);
            chk($sformatf("halt%0d ready", k),   32'(instr_ready), 32'd0);
            chk($sformatf("halt%0d rw", k),      32'(reg_w0_rw),   32'd0);
            chk($sformatf("halt%0d cv", k),      32'(ctrl_valid),  32'd0);
            chk($sformatf("halt%0d illegal", k), 32'(illegal),     32'd1);
        end
        do_reset("halt exit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
